riscv_mem_arbiter: RTL and testbench

//  Shares the single riscv_memory_iface port between instruction fetch (I) and load/store (D).

---
 rtl/riscv_mem_arbiter_pkg.sv | 22 ++
 rtl/riscv_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: access size codes and response owner tags.
package riscv_mem_arbiter_pkg;

    // Access size codes understood by the memory interface.
    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    // Owner of an in-flight read response.
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Which requester (if any) owns the memory port this cycle.
    typedef enum logic [1:0] {
        GntNone = 2'b00,
        GntI    = 2'b01,
        GntD    = 2'b10
    } gnt_e;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single pipelined memory interface.
// D has priority; I is guaranteed a grant after STARVE_LIMIT consecutive contended D grants.
// Granted reads are tagged and the returning data is steered to its owner.
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,

    input  logic        i_req_in,
    input  logic [31:0] i_addr_in,
    output logic        i_gnt_out,
    output logic        i_rvalid_out,
    output logic [31:0] i_rdata_out,

    input  logic        d_req_in,
    input  logic [31:0] d_addr_in,
    input  logic [31:0] d_wdata_in,
    input  logic [2:0]  d_size_in,
    input  logic        d_we_in,
    output logic        d_gnt_out,
    output logic        d_rvalid_out,
    output logic [31:0] d_rdata_out,

    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_data_out,
    output logic [2:0]  mem_size_out,
    output logic        mem_we_out,
    output logic        mem_re_out,
    input  logic [31:0] mem_data_in
);

    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

    gnt_e                  gnt_sel;
    logic [CntW-1:0]       starve_q, starve_d;
    logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [READ_LATENCY-1:0] tag_own_q, tag_own_d;
    logic                  rsp_vld;
    logic                  rsp_own;

    // Pick the single requester served this cycle.
    always_comb begin
        gnt_sel = GntNone;
        if (d_req_in && i_req_in) begin
            gnt_sel = (starve_q == StarveMax) ? GntI : GntD;
        end else if (d_req_in) begin
            gnt_sel = GntD;
        end else if (i_req_in) begin
            gnt_sel = GntI;
        end
    end

    assign i_gnt_out = (gnt_sel == GntI);
    assign d_gnt_out = (gnt_sel == GntD);

    // Count D grants taken while I is waiting; any I grant or idle I clears it.
    always_comb begin
        starve_d = starve_q;
        if (i_gnt_out || !i_req_in) begin
            starve_d = '0;
        end else if (d_gnt_out && (starve_q != StarveMax)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Drive the memory interface from the granted requester.
    always_comb begin
        mem_addr_out = '0;
        mem_data_out = '0;
        mem_size_out = '0;
        mem_we_out   = 1'b0;
        mem_re_out   = 1'b0;
        unique case (gnt_sel)
            GntD: begin
                mem_addr_out = d_addr_in;
                mem_data_out = d_wdata_in;
                mem_size_out = d_size_in;
                mem_we_out   = d_we_in;
                mem_re_out   = ~d_we_in;
            end
            GntI: begin
                mem_addr_out = i_addr_in;
                mem_size_out = MASK_W;
                mem_re_out   = 1'b1;
            end
            default: ;
        endcase
    end

    // Tag pipe next state: stage 0 takes this cycle's read grant, the rest shift along.
    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_own_d    = tag_own_q;
        tag_vld_d[0] = mem_re_out;
        tag_own_d[0] = d_gnt_out ? OWNER_D : OWNER_I;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_own_d[i] = tag_own_q[i-1];
        end
    end

    // State registers; reset drops every in-flight tag immediately.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            starve_q  <= '0;
            tag_vld_q <= '0;
            tag_own_q <= '0;
        end else begin
            starve_q  <= starve_d;
            tag_vld_q <= tag_vld_d;
            tag_own_q <= tag_own_d;
        end
    end

    assign rsp_vld = tag_vld_q[READ_LATENCY-1];
    assign rsp_own = tag_own_q[READ_LATENCY-1];

    // Steer returning read data to its owner; the other port sees zeros.
    always_comb begin
        i_rvalid_out = rsp_vld && (rsp_own == OWNER_I);
        d_rvalid_out = rsp_vld && (rsp_own == OWNER_D);
        i_rdata_out  = i_rvalid_out ? mem_data_in : '0;
        d_rdata_out  = d_rvalid_out ? mem_data_in : '0;
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a behavioural pipelined memory behind it.
module tb_riscv_mem_arbiter;
    import riscv_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [2:0]  d_size;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_size;
    logic        mem_we, mem_re;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.READ_LATENCY(2), .STARVE_LIMIT(4)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .i_req_in     (i_req),
        .i_addr_in    (i_addr),
        .i_gnt_out    (i_gnt),
        .i_rvalid_out (i_rvalid),
        .i_rdata_out  (i_rdata),
        .d_req_in     (d_req),
        .d_addr_in    (d_addr),
        .d_wdata_in   (d_wdata),
        .d_size_in    (d_size),
        .d_we_in      (d_we),
        .d_gnt_out    (d_gnt),
        .d_rvalid_out (d_rvalid),
        .d_rdata_out  (d_rdata),
        .mem_addr_out (mem_addr),
        .mem_data_out (mem_wdata),
        .mem_size_out (mem_size),
        .mem_we_out   (mem_we),
        .mem_re_out   (mem_re),
        .mem_data_in  (mem_rdata)
    );

    // ---------------- memory model: iface + 2-stage pipelined BRAM ----------------
    logic [31:0] mem [0:1023];
    logic [31:0] rd0_q = '0;
    logic [31:0] rd1_q = '0;
    assign mem_rdata = rd1_q;

    function automatic logic misaligned(input logic [31:0] a, input logic [2:0] s);
        case (s)
            MASK_H, MASK_HU: return a[0];
            MASK_W:          return a[1:0] != 2'b00;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] s);
        logic [31:0] sh;
        sh = w >> (a[1:0] * 8);
        if (misaligned(a, s)) return 32'h0;
        case (s)
            MASK_B:  return {{24{sh[7]}}, sh[7:0]};
            MASK_BU: return {24'h0, sh[7:0]};
            MASK_H:  return {{16{sh[15]}}, sh[15:0]};
            MASK_HU: return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_we && !misaligned(mem_addr, mem_size)) begin
            case (mem_size)
                MASK_B:  mem[mem_addr[11:2]][mem_addr[1:0]*8 +: 8]   <= mem_wdata[7:0];
                MASK_H:  mem[mem_addr[11:2]][mem_addr[1]*16 +: 16]   <= mem_wdata[15:0];
                default: mem[mem_addr[11:2]]                         <= mem_wdata;
            endcase
        end
        rd0_q <= mem_re ? load_val(mem[mem_addr[11:2]], mem_addr, mem_size) : 32'h0;
        rd1_q <= rd0_q;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_size = MASK_W;
    endtask

    task automatic d_op(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd);
        d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    endtask

    task automatic i_op(input logic [31:0] a);
        i_req = 1'b1; i_addr = a;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        i_req;
        logic        d_req;
        logic        d_we;
        logic [2:0]  d_size;
        logic [31:0] i_addr;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_ig;
        logic        e_dg;
        logic        e_re;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [2:0]  e_size;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic ir, input logic dr, input logic we,
                                input logic [2:0] sz, input logic [31:0] ia,
                                input logic [31:0] da, input logic [31:0] wd,
                                input logic eig, input logic edg, input logic ere,
                                input logic ewe, input logic [31:0] ea,
                                input logic [31:0] ed, input logic [2:0] es);
        vec_t v;
        v = '{ir, dr, we, sz, ia, da, wd, eig, edg, ere, ewe, ea, ed, es};
        return v;
    endfunction

    initial begin
        // idle, I only, D load, D store
        vecs[0]  = mk(0, 0, 0, MASK_W, 32'h50, 32'h40, 32'h77,   0, 0, 0, 0, 32'h0,  32'h0,    3'b000);
        vecs[1]  = mk(1, 0, 0, MASK_W, 32'h50, 32'h40, 32'h77,   1, 0, 1, 0, 32'h50, 32'h0,    MASK_W);
        vecs[2]  = mk(0, 1, 0, MASK_H, 32'h50, 32'h44, 32'h77,   0, 1, 1, 0, 32'h44, 32'h77,   MASK_H);
        vecs[3]  = mk(0, 1, 1, MASK_W, 32'h50, 32'h48, 32'h1234, 0, 1, 0, 1, 32'h48, 32'h1234, MASK_W);
        // contention: D,D,D,D,I,D,D,D,D,I
        for (int k = 4; k < 14; k++) begin
            if (k == 8 || k == 13)
                vecs[k] = mk(1, 1, 0, MASK_W, 32'h54, 32'h40, 32'h99, 1, 0, 1, 0, 32'h54, 32'h0,  MASK_W);
            else
                vecs[k] = mk(1, 1, 0, MASK_W, 32'h54, 32'h40, 32'h99, 0, 1, 1, 0, 32'h40, 32'h99, MASK_W);
        end
        // contended store (count 1), I drops (count 0), contended again -> D
        vecs[14] = mk(1, 1, 1, MASK_B, 32'h54, 32'h41, 32'hAB,   0, 1, 0, 1, 32'h41, 32'hAB,   MASK_B);
        vecs[15] = mk(0, 1, 0, MASK_W, 32'h54, 32'h40, 32'h5,    0, 1, 1, 0, 32'h40, 32'h5,    MASK_W);
        vecs[16] = mk(1, 1, 0, MASK_W, 32'h54, 32'h40, 32'h6,    0, 1, 1, 0, 32'h40, 32'h6,    MASK_W);
        vecs[17] = mk(0, 0, 0, MASK_W, 32'h54, 32'h40, 32'h6,    0, 0, 0, 0, 32'h0,  32'h0,    3'b000);
    end

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        chk("reset_i_rvalid", {31'b0, i_rvalid}, 32'd0);
        chk("reset_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        chk("reset_i_rdata", i_rdata, 32'h0);
        chk("reset_d_rdata", d_rdata, 32'h0);
        tick();
        rst = 1'b0;

        // 1: idle
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_re_we", {30'b0, mem_re, mem_we}, 32'd0);
            chk("idle_gnt", {30'b0, i_gnt, d_gnt}, 32'd0);
            chk("idle_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
            tick();
        end

        // table vectors: grants and memory drive
        for (int k = 0; k < NVEC; k++) begin
            i_req = vecs[k].i_req; d_req = vecs[k].d_req; d_we = vecs[k].d_we;
            d_size = vecs[k].d_size; i_addr = vecs[k].i_addr; d_addr = vecs[k].d_addr;
            d_wdata = vecs[k].d_wdata;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", k), {30'b0, i_gnt, d_gnt}, {30'b0, vecs[k].e_ig, vecs[k].e_dg});
            chk($sformatf("vec%0d_re_we", k), {30'b0, mem_re, mem_we}, {30'b0, vecs[k].e_re, vecs[k].e_we});
            chk($sformatf("vec%0d_addr", k), mem_addr, vecs[k].e_addr);
            chk($sformatf("vec%0d_data", k), mem_wdata, vecs[k].e_data);
            chk($sformatf("vec%0d_size", k), {29'b0, mem_size}, {29'b0, vecs[k].e_size});
            tick();
        end
        drive_idle();
        tick(); tick(); tick();

        // 2: I only fetch of 0xDEADBEEF
        d_op(1'b1, MASK_W, 32'h100, 32'hDEADBEEF);
        tick();
        drive_idle();
        i_op(32'h100);
        @(negedge clk);
        chk("fetch_gnt", {30'b0, i_gnt, d_gnt}, 32'd2);
        tick();
        drive_idle();
        @(negedge clk);
        chk("fetch_rvalid_early", {31'b0, i_rvalid}, 32'd0);
        tick();
        @(negedge clk);
        chk("fetch_rvalid", {31'b0, i_rvalid}, 32'd1);
        chk("fetch_rdata", i_rdata, 32'hDEADBEEF);
        chk("fetch_no_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        tick();
        @(negedge clk);
        chk("fetch_rvalid_once", {31'b0, i_rvalid}, 32'd0);
        tick();

        // 4: interleave D load then I fetch
        d_op(1'b1, MASK_W, 32'h200, 32'h11223344); tick();
        d_op(1'b1, MASK_W, 32'h204, 32'h55667788); tick();
        drive_idle(); tick();
        d_op(1'b0, MASK_W, 32'h200, 32'h0);
        @(negedge clk);
        chk("il_d_gnt", {31'b0, d_gnt}, 32'd1);
        tick();
        drive_idle();
        i_op(32'h204);
        @(negedge clk);
        chk("il_i_gnt", {31'b0, i_gnt}, 32'd1);
        tick();
        drive_idle();
        @(negedge clk);
        chk("il_d_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd1);
        chk("il_d_rdata", d_rdata, 32'h11223344);
        tick();
        @(negedge clk);
        chk("il_i_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd2);
        chk("il_i_rdata", i_rdata, 32'h55667788);
        chk("il_d_rdata_zero", d_rdata, 32'h0);
        tick();
        // SB then LBU
        d_op(1'b1, MASK_B, 32'h203, 32'hFFFFFF12); tick();
        d_op(1'b0, MASK_BU, 32'h203, 32'h0); tick();
        // misaligned LW straight after: returns rvalid with 0
        d_op(1'b0, MASK_W, 32'h302, 32'h0);
        @(negedge clk);
        chk("sb_lbu_pending", {31'b0, d_rvalid}, 32'd0);
        tick();
        drive_idle();
        @(negedge clk);
        chk("lbu_rvalid", {31'b0, d_rvalid}, 32'd1);
        chk("lbu_rdata", d_rdata, 32'h00000012);
        tick();
        @(negedge clk);
        chk("misal_rvalid", {31'b0, d_rvalid}, 32'd1);
        chk("misal_rdata", d_rdata, 32'h0);
        tick();

        // 5: store only
        d_op(1'b1, MASK_W, 32'h300, 32'hCAFEF00D);
        @(negedge clk);
        chk("sw_re_we", {30'b0, mem_re, mem_we}, 32'd1);
        chk("sw_gnt", {31'b0, d_gnt}, 32'd1);
        tick();
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("sw_no_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
            tick();
        end
        d_op(1'b0, MASK_W, 32'h300, 32'h0);
        tick();
        drive_idle();
        tick();
        @(negedge clk);
        chk("lw_after_sw", d_rdata, 32'hCAFEF00D);
        tick();

        // 6: reset with a load in flight and the starve counter at its limit
        i_op(32'h400);
        d_op(1'b0, MASK_W, 32'h200, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_pre_d_gnt", {30'b0, i_gnt, d_gnt}, 32'd1);
            if (c >= 2) chk("rst_pre_d_rvalid", {31'b0, d_rvalid}, 32'd1);
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cnt_cleared_gnt", {30'b0, i_gnt, d_gnt}, 32'd1);
        chk("rst_d_rvalid_dropped", {31'b0, d_rvalid}, 32'd0);
        tick();
        rst = 1'b0;
        d_we = 1'b1;
        @(negedge clk);
        chk("post_rst_contended_gnt", {30'b0, i_gnt, d_gnt}, 32'd1);
        chk("post_rst_no_rvalid", {31'b0, d_rvalid}, 32'd0);
        tick();
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_quiet", {30'b0, i_rvalid, d_rvalid}, 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
